// File: rtl/eggtimer_pkg.sv
// Shared types and constants for the egg timer setpoint entry and countdown chain.
package eggtimer_pkg;

   typedef enum logic [1:0] {
      EDIT = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SEC_ONES_MAX = 9;
   localparam int SEC_TENS_MAX = 5;
   localparam int MIN_MAX      = 9;

   localparam logic [1:0] IDX_S0 = 2'd0;
   localparam logic [1:0] IDX_S1 = 2'd1;
   localparam logic [1:0] IDX_M0 = 2'd2;
   localparam logic [1:0] IDX_M1 = 2'd3;

   // Largest legal BCD value for each digit position.
   function automatic int digit_max(input logic [1:0] idx);
      case (idx)
         IDX_S0:  return SEC_ONES_MAX;
         IDX_S1:  return SEC_TENS_MAX;
         default: return MIN_MAX;
      endcase
   endfunction

endpackage

// File: rtl/button_repeat.sv
// Edge detect plus tick-based auto-repeat for one held button; emits a one-cycle step.
module button_repeat #(
   parameter int REPEAT_DELAY = 5,
   parameter int REPEAT_RATE  = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic tick,
   input  logic clear,
   output logic step,
   output logic rise
);

   localparam int CW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
   localparam logic [CW-1:0] FIRST = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] NEXT  = CW'(REPEAT_DELAY + REPEAT_RATE);

   logic          prev;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          rpt;

   assign rise    = btn & ~prev;
   assign cnt_inc = cnt + CW'(1);
   assign rpt     = btn & tick & ((cnt_inc == FIRST) || (cnt_inc == NEXT));
   assign step    = ~clear & (rise | rpt);

   // After the first repeat the count folds back to REPEAT_DELAY, so it cycles every REPEAT_RATE ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 1'b0;
         cnt  <= '0;
      end else begin
         prev <= btn;
         if (!btn || clear)
            cnt <= '0;
         else if (tick)
            cnt <= (cnt_inc == NEXT) ? FIRST : cnt_inc;
      end
   end

endmodule

// File: rtl/timer_setpoint_entry.sv
// Setpoint entry FSM for the MM:SS countdown chain: edits BCD digits, issues load/run, raises alarm.
module timer_setpoint_entry
   import eggtimer_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int REPEAT_DELAY = 5,
   parameter int REPEAT_RATE  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               btn_inc,
   input  logic               btn_dec,
   input  logic               btn_next,
   input  logic               btn_start,
   input  logic               timer_done,
   output logic [4*WIDTH-1:0] setpoint,
   output logic [1:0]         sel,
   output logic               load,
   output logic               run,
   output logic               alarm
);

   state_t                 state;
   logic [3:0][WIDTH-1:0]  digits;
   logic                   both;
   logic                   inc_step, dec_step, inc_rise, dec_rise;
   logic [WIDTH-1:0]       cur, mx, inc_val, dec_val;

   assign both = btn_inc & btn_dec;

   button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_inc),
      .tick  (tick),
      .clear (both),
      .step  (inc_step),
      .rise  (inc_rise)
   );

   button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dec (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_dec),
      .tick  (tick),
      .clear (both),
      .step  (dec_step),
      .rise  (dec_rise)
   );

   // Per-digit wrap, no carry or borrow into neighbours.
   assign cur     = digits[sel];
   assign mx      = WIDTH'(digit_max(sel));
   assign inc_val = (cur >= mx) ? '0 : cur + WIDTH'(1);
   assign dec_val = (cur == '0) ? mx : cur - WIDTH'(1);

   assign setpoint = digits;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EDIT;
         digits <= '0;
         sel    <= IDX_S0;
         load   <= 1'b0;
         run    <= 1'b0;
         alarm  <= 1'b0;
      end else begin
         load <= 1'b0;
         case (state)
            EDIT: begin
               if (btn_start) begin
                  if (digits != '0) begin
                     state <= RUN;
                     load  <= 1'b1;
                     run   <= 1'b1;
                  end
               end else if (btn_next) begin
                  sel <= sel + 2'd1;
               end else if (inc_step) begin
                  digits[sel] <= inc_val;
               end else if (dec_step) begin
                  digits[sel] <= dec_val;
               end
            end
            RUN: begin
               // load is high only in the first RUN cycle, while the chain still shows stale zeros.
               if (btn_start) begin
                  state <= EDIT;
                  run   <= 1'b0;
               end else if (timer_done && !load) begin
                  state <= DONE;
                  run   <= 1'b0;
                  alarm <= 1'b1;
               end
            end
            DONE: begin
               if (btn_start || btn_next || inc_rise || dec_rise) begin
                  state <= EDIT;
                  alarm <= 1'b0;
               end
            end
            default: begin
               state <= EDIT;
               run   <= 1'b0;
               alarm <= 1'b0;
            end
         endcase
      end
   end

endmodule
